// File: rtl/ram_load_ctrl.sv
// Program-load controller: receives a LEN/payload/CSUM byte frame and writes
// the payload into RAM from address 0, holding the CPU halted until it succeeds.
module ram_load_ctrl #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              cpu_ram_we,
  input  logic [ADDR_W-1:0] cpu_ram_addr,
  input  logic [7:0]        cpu_ram_wdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [8:0]    DEPTH9   = 9'(DEPTH);
  localparam logic [ADDR_W:0] RC_ONE = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        sum_q, sum_d;
  logic [ADDR_W:0]   rcount_q, rcount_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;

  logic       in_frame;
  logic [8:0] len9;

  assign in_frame = (state_q == S_LEN) ||
                    (state_q == S_DATA) ||
                    (state_q == S_CSUM);
  assign len9 = {1'b0, rx_data};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    sum_d    = sum_q;
    rcount_d = rcount_q;
    tmo_d    = tmo_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;

    // Idle-cycle counter only runs inside a frame and never wraps.
    if (in_frame) begin
      if (rx_valid) begin
        tmo_d = '0;
      end else if (tmo_q != TMO_MAX) begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (load_req) begin
          state_d  = S_LEN;
          addr_d   = '0;
          sum_d    = '0;
          rcount_d = '0;
          tmo_d    = '0;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          if (len9 == 9'd0 || len9 > DEPTH9) begin
            state_d = S_ERR;
          end else begin
            rcount_d = len9[ADDR_W:0];
            state_d  = S_DATA;
          end
        end else if (tmo_q >= TMO_LAST) begin
          state_d = S_ERR;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          we_d     = 1'b1;
          waddr_d  = addr_q;
          wdata_d  = rx_data;
          addr_d   = addr_q + 1'b1;
          sum_d    = sum_q + rx_data;
          rcount_d = rcount_q - 1'b1;
          if (rcount_q == RC_ONE) state_d = S_CSUM;
        end else if (tmo_q >= TMO_LAST) begin
          state_d = S_ERR;
        end
      end
      S_CSUM: begin
        if (rx_valid) begin
          state_d = (rx_data == sum_q) ? S_RUN : S_ERR;
        end else if (tmo_q >= TMO_LAST) begin
          state_d = S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      sum_q    <= '0;
      rcount_q <= '0;
      tmo_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      sum_q    <= sum_d;
      rcount_q <= rcount_d;
      tmo_q    <= tmo_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // The CPU owns the RAM port only while its program is running.
  assign ram_we    = done ? cpu_ram_we    : we_q;
  assign ram_addr  = done ? cpu_ram_addr  : waddr_q;
  assign ram_wdata = done ? cpu_ram_wdata : wdata_q;

  assign done     = (state_q == S_RUN);
  assign cpu_halt = ~done;
  assign busy     = in_frame;
  assign err      = (state_q == S_ERR);

endmodule

// File: tb/tb_ram_load_ctrl.sv
// Scoreboard bench for ram_load_ctrl: a frame-level model queues the expected
// RAM writes and final status; a monitor pops and checks each loader write.
module tb_ram_load_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int TMO   = 8;

  logic          i_clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_req = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          cpu_ram_we = 1'b0;
  logic [AW-1:0] cpu_ram_addr = '0;
  logic [7:0]    cpu_ram_wdata = '0;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          cpu_halt, busy, done, err;

  ram_load_ctrl #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .reset(reset), .load_req(load_req),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .cpu_ram_we(cpu_ram_we), .cpu_ram_addr(cpu_ram_addr),
    .cpu_ram_wdata(cpu_ram_wdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .cpu_halt(cpu_halt), .busy(busy), .done(done), .err(err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stim[$];
  logic [7:0] ram[DEPTH];
  logic [7:0] mem_m[DEPTH];
  bit         mem_v[DEPTH];
  int         n_checks = 0;
  int         n_pass = 0;
  int         gapmax = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got %0h want %0h", name, act, exp);
  endtask

  always @(posedge i_clk) if (ram_we) ram[ram_addr] <= ram_wdata;

  // Loader writes (outside RUN) must match the scoreboard in order.
  always @(negedge i_clk) begin
    if (reset && ram_we && !done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(ram_addr), 32'hFFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(ram_addr), 32'(e.a));
        check("wr_data", 32'(ram_wdata), 32'(e.d));
      end
    end
  end

  task automatic drive_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge i_clk);
    #1;
    rx_valid = 1'b0;
    load_req = 1'b0;
  endtask

  task automatic pulse_req(input bit junk);
    load_req = 1'b1;
    if (junk) begin
      rx_data  = 8'h00;
      rx_valid = 1'b1;
    end
    @(posedge i_clk);
    #1;
    load_req = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic model_write(input int a, input logic [7:0] d);
    wr_t w;
    w.a = 4'(a);
    w.d = d;
    exp_q.push_back(w);
    mem_m[a] = d;
    mem_v[a] = 1'b1;
  endtask

  task automatic run_frame(input bit junk, input int lr_at);
    int         len;
    bit         bad, ok;
    logic [7:0] s;
    len = int'(stim[0]);
    bad = (len == 0) || (len > DEPTH);
    s   = 8'h00;
    pulse_req(junk);
    @(negedge i_clk);
    check("req_busy", 32'(busy), 1);
    check("req_halt", 32'(cpu_halt), 1);
    check("req_no_we", 32'(ram_we), 0);
    for (int i = 0; i < stim.size(); i++) begin
      repeat ($urandom_range(0, gapmax)) @(posedge i_clk);
      #1;
      if (i == lr_at) load_req = 1'b1;
      if (!bad && i >= 1 && i <= len) begin
        model_write(i - 1, stim[i]);
        s = s + stim[i];
      end
      drive_byte(stim[i]);
      if (i == 0 && bad) begin
        @(negedge i_clk);
        check("badlen_err", 32'(err), 1);
      end
    end
    ok = !bad && (stim[len + 1] == s);
    @(negedge i_clk);
    check("end_done", 32'(done), 32'(ok));
    check("end_err", 32'(err), 32'(!ok));
    check("end_halt", 32'(cpu_halt), 32'(!ok));
    check("end_busy", 32'(busy), 0);
    #1;
    check("wr_count", 32'(exp_q.size()), 0);
  endtask

  task automatic build_good(input int len, input bit corrupt);
    logic [7:0] s;
    logic [7:0] b;
    s = 8'h00;
    stim = {};
    stim.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(0, 255));
      stim.push_back(b);
      s = s + b;
    end
    if (corrupt) s = s + 8'($urandom_range(1, 255));
    stim.push_back(s);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    for (int i = 0; i < DEPTH; i++) mem_v[i] = 1'b0;
    #12;
    check("rst_we", 32'(ram_we), 0);
    check("rst_addr", 32'(ram_addr), 0);
    check("rst_wdata", 32'(ram_wdata), 0);
    check("rst_halt", 32'(cpu_halt), 1);
    check("rst_flags", 32'({busy, done, err}), 0);
    @(negedge i_clk);
    reset = 1'b1;
    @(negedge i_clk);
    check("idle_halt", 32'(cpu_halt), 1);

    // good load, one byte per cycle
    gapmax = 0;
    stim = {8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    run_frame(0, -1);
    cpu_ram_we    = 1'b1;
    cpu_ram_addr  = 4'h5;
    cpu_ram_wdata = 8'hA5;
    #1;
    check("run_mux_we", 32'(ram_we), 1);
    check("run_mux_addr", 32'(ram_addr), 5);
    check("run_mux_data", 32'(ram_wdata), 32'hA5);
    mem_m[5] = 8'hA5;
    mem_v[5] = 1'b1;
    @(negedge i_clk);
    cpu_ram_we = 1'b0;

    // checksum error, then CPU writes must be blocked
    stim = {8'h03, 8'h11, 8'h22, 8'h33, 8'h65};
    run_frame(0, -1);
    cpu_ram_we    = 1'b1;
    cpu_ram_addr  = 4'h9;
    cpu_ram_wdata = 8'h77;
    #1;
    check("err_cpu_we_blocked", 32'(ram_we), 0);
    @(negedge i_clk);
    cpu_ram_we = 1'b0;

    // bad lengths
    stim = {8'h00, 8'h05, 8'h06};
    run_frame(0, -1);
    stim = {8'(DEPTH + 1), 8'h01, 8'h02};
    run_frame(0, -1);

    // full depth, sum wraps to F0
    stim = {8'(DEPTH)};
    for (int i = 0; i < DEPTH; i++) stim.push_back(8'hFF);
    stim.push_back(8'hF0);
    run_frame(0, -1);

    // timeout after one data byte
    pulse_req(0);
    drive_byte(8'h02);
    model_write(0, 8'h5A);
    drive_byte(8'h5A);
    @(negedge i_clk);
    repeat (7) @(negedge i_clk);
    check("tmo_not_yet", 32'(err), 0);
    check("tmo_busy", 32'(busy), 1);
    @(negedge i_clk);
    check("tmo_err", 32'(err), 1);
    check("tmo_halt", 32'(cpu_halt), 1);
    build_good(5, 0);
    run_frame(0, -1);

    // load_req mid-DATA ignored; load_req with a byte from RUN
    gapmax = 1;
    build_good(6, 0);
    run_frame(0, 3);
    build_good(4, 0);
    run_frame(1, -1);

    // reset mid-DATA
    pulse_req(0);
    drive_byte(8'h04);
    ra = 8'($urandom_range(0, 255));
    rb = 8'($urandom_range(0, 255));
    model_write(0, ra);
    drive_byte(ra);
    model_write(1, rb);
    drive_byte(rb);
    @(negedge i_clk);
    #1;
    reset = 1'b0;
    #1;
    check("mrst_we", 32'(ram_we), 0);
    check("mrst_addr", 32'(ram_addr), 0);
    check("mrst_wdata", 32'(ram_wdata), 0);
    check("mrst_halt", 32'(cpu_halt), 1);
    check("mrst_flags", 32'({busy, done, err}), 0);
    @(negedge i_clk);
    reset = 1'b1;
    @(negedge i_clk);
    check("mrst_idle", 32'({cpu_halt, busy, done, err}), 32'b1000);
    check("mrst_q", 32'(exp_q.size()), 0);

    // randomized frames
    gapmax = 2;
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        stim = {($urandom_range(0, 1) != 0) ? 8'h00
                : 8'(DEPTH + 1 + $urandom_range(0, 5)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        run_frame($urandom_range(0, 3) == 0, -1);
      end else begin
        build_good($urandom_range(1, DEPTH), $urandom_range(0, 9) < 3);
        run_frame($urandom_range(0, 3) == 0,
                  ($urandom_range(0, 2) == 0) ?
                  int'($urandom_range(1, 2)) : -1);
      end
    end

    @(negedge i_clk);
    for (int i = 0; i < DEPTH; i++)
      if (mem_v[i]) check($sformatf("ram_%0d", i), 32'(ram[i]), 32'(mem_m[i]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
